// File: rtl/freq_sel_pkg.sv
// Shared defaults and stream state encoding for the freq_selector sample path.
package freq_sel_pkg;

  localparam int unsigned DEF_DATA_W = 14;
  localparam int unsigned DEF_ADDR_W = 7;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/ring_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one read port, read-first,
// RD_LAT output registers (no reset; validity is tracked by the caller).
module ring_sdp_ram #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q   [RD_LAT];

  // Non-blocking update of mem makes a same-cycle read return the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q[0] <= mem[raddr];
    for (int i = 1; i < RD_LAT; i++) q[i] <= q[i-1];
  end

  assign rdata = q[RD_LAT-1];

endmodule

// File: rtl/ring_stream_ra.sv
// Circular sample store with a looping valid/ready replay stream and a
// random-access read port sharing one RAM read port (RA has priority).
module ring_stream_ra
  import freq_sel_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned PF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              clear,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_index,
  output logic              s_last,
  output logic [ADDR_W:0]   fill,
  input  logic              ra_req,
  input  logic              ra_rel,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic              ra_ack,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned FW    = ADDR_W + 1;
  localparam int unsigned PF_AW = $clog2(PF_DEPTH);
  localparam int unsigned PCW   = PF_AW + 1;
  localparam int unsigned CW    = PF_AW + 2;

  stream_state_t     st, st_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, iss_addr, ram_raddr;
  logic [ADDR_W-1:0] oldest, newest, ra_phys;
  logic [FW-1:0]     fill_q;
  logic [DATA_W-1:0] ram_q;
  logic              issue, ra_acc, ra_busy, wr_go, flush_now, pop, push, credit_ok;
  logic [CW-1:0]     n_out;

  logic              sp_v    [RD_LAT];
  logic [ADDR_W-1:0] sp_idx  [RD_LAT];
  logic              sp_last [RD_LAT];
  logic              ra_v    [RD_LAT];

  logic [DATA_W-1:0] pf_data [PF_DEPTH];
  logic [ADDR_W-1:0] pf_idx  [PF_DEPTH];
  logic              pf_last [PF_DEPTH];
  logic [PF_AW-1:0]  pf_wp, pf_rp;
  logic [PCW-1:0]    pf_cnt;

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi);
    return (p == hi) ? lo : p + ADDR_W'(1);
  endfunction

  // Write pointer and fill; clear beats a same-cycle write.
  assign wr_go     = wr_en && !clear && !rst;
  assign flush_now = wr_en || clear;
  assign oldest    = (fill_q < FW'(DEPTH)) ? '0 : wr_ptr;
  assign newest    = wr_ptr - ADDR_W'(1);
  assign fill      = fill_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      fill_q <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
    end
  end

  ring_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // Random-access pipeline: one request in flight, untouched by write/clear.
  always_comb begin
    ra_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) ra_busy = ra_busy | ra_v[i];
  end

  assign ra_acc    = ra_req && !ra_busy && !rst;
  assign ra_phys   = ra_rel ? (newest - ra_addr) : ra_addr;
  assign ram_raddr = ra_acc ? ra_phys : iss_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) ra_v[i] <= 1'b0;
      ra_ack   <= 1'b0;
      ra_valid <= 1'b0;
      ra_data  <= '0;
    end else begin
      ra_v[0] <= ra_acc;
      for (int i = 1; i < RD_LAT; i++) ra_v[i] <= ra_v[i-1];
      ra_ack   <= ra_acc;
      ra_valid <= ra_v[RD_LAT-1];
      if (ra_v[RD_LAT-1]) ra_data <= ram_q;
    end
  end

  // Credits: FIFO occupancy (net of this cycle's pop) plus live reads in flight.
  always_comb begin
    n_out = '0;
    for (int i = 0; i < RD_LAT; i++) n_out = n_out + CW'(sp_v[i]);
  end

  assign pop       = s_valid && s_ready;
  assign credit_ok = (CW'(pf_cnt) - CW'(pop) + n_out) < CW'(PF_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_EMPTY;
      rd_ptr <= '0;
    end else begin
      st     <= st_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // The flush cycle already issues the oldest read to hit RD_LAT+1 latency.
  always_comb begin
    st_nxt     = st;
    issue      = 1'b0;
    rd_ptr_nxt = rd_ptr;
    iss_addr   = rd_ptr;
    case (st)
      S_EMPTY: ;
      S_FLUSH: begin
        iss_addr   = oldest;
        rd_ptr_nxt = oldest;
        st_nxt     = S_RUN;
        if (!ra_acc) begin
          issue      = 1'b1;
          rd_ptr_nxt = next_ptr(oldest, oldest, newest);
        end
      end
      S_RUN: begin
        if (!ra_acc && credit_ok) begin
          issue      = 1'b1;
          rd_ptr_nxt = next_ptr(rd_ptr, oldest, newest);
        end
      end
      default: st_nxt = S_EMPTY;
    endcase
    if (clear)      st_nxt = S_EMPTY;
    else if (wr_en) st_nxt = S_FLUSH;
  end

  // Stream read tags; a write or clear kills everything in flight and queued.
  assign push = sp_v[RD_LAT-1];

  always_ff @(posedge clk) begin
    sp_idx[0]  <= iss_addr;
    sp_last[0] <= (iss_addr == newest);
    for (int i = 1; i < RD_LAT; i++) begin
      sp_idx[i]  <= sp_idx[i-1];
      sp_last[i] <= sp_last[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_now) begin
      for (int i = 0; i < RD_LAT; i++) sp_v[i] <= 1'b0;
      pf_wp  <= '0;
      pf_rp  <= '0;
      pf_cnt <= '0;
    end else begin
      sp_v[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) sp_v[i] <= sp_v[i-1];
      if (push) pf_wp <= pf_wp + PF_AW'(1);
      if (pop)  pf_rp <= pf_rp + PF_AW'(1);
      pf_cnt <= pf_cnt + PCW'(push) - PCW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PF_DEPTH; i++) begin
        pf_data[i] <= '0;
        pf_idx[i]  <= '0;
        pf_last[i] <= 1'b0;
      end
    end else if (push && !flush_now) begin
      pf_data[pf_wp] <= ram_q;
      pf_idx[pf_wp]  <= sp_idx[RD_LAT-1];
      pf_last[pf_wp] <= sp_last[RD_LAT-1];
    end
  end

  assign s_valid = (pf_cnt != '0);
  assign s_data  = pf_data[pf_rp];
  assign s_index = pf_idx[pf_rp];
  assign s_last  = pf_last[pf_rp];

endmodule
